// File: rtl/memory_stage.sv
// Pipeline MEM stage: aligned data-memory requests over ready/valid, load extension,
// MEM-stage forwarding and the MEM/WB pipeline register.
module memory_stage #(
  parameter int unsigned ADDR_WIDTH = 64,
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned REG_ADDR_W = 5
) (
  input  logic                  i_clk,
  input  logic                  i_arst,
  input  logic [2:0]            i_result_src,
  input  logic                  i_mem_we,
  input  logic                  i_reg_we,
  input  logic                  i_mem_access,
  input  logic [2:0]            i_func3,
  input  logic [ADDR_WIDTH-1:0] i_pc_plus4,
  input  logic [ADDR_WIDTH-1:0] i_pc_target,
  input  logic [DATA_WIDTH-1:0] i_imm_ext,
  input  logic [DATA_WIDTH-1:0] i_alu_result,
  input  logic [DATA_WIDTH-1:0] i_write_data,
  input  logic [1:0]            i_forward_src,
  input  logic [REG_ADDR_W-1:0] i_rd_addr,
  output logic                  o_dmem_req,
  output logic                  o_dmem_we,
  output logic [ADDR_WIDTH-1:0] o_dmem_addr,
  output logic [DATA_WIDTH-1:0] o_dmem_wdata,
  output logic [7:0]            o_dmem_be,
  input  logic                  i_dmem_ready,
  input  logic                  i_dmem_rvalid,
  input  logic [DATA_WIDTH-1:0] i_dmem_rdata,
  output logic                  o_stall_mem,
  output logic                  o_misaligned,
  output logic [DATA_WIDTH-1:0] o_forward_value,
  output logic [2:0]            o_result_src,
  output logic                  o_reg_we,
  output logic [REG_ADDR_W-1:0] o_rd_addr,
  output logic [ADDR_WIDTH-1:0] o_pc_plus4,
  output logic [ADDR_WIDTH-1:0] o_pc_target,
  output logic [DATA_WIDTH-1:0] o_imm_ext,
  output logic [DATA_WIDTH-1:0] o_alu_result,
  output logic [DATA_WIDTH-1:0] o_read_data
);

  localparam int unsigned OFF_W = 3;

  typedef enum logic [1:0] {IDLE, REQ, WAIT_RD} state_t;

  state_t                state, state_next;
  logic [OFF_W-1:0]      off;
  logic [5:0]            lane_shift;
  logic                  misaligned;
  logic                  access_ok;
  logic                  is_load;
  logic [7:0]            base_be;
  logic [DATA_WIDTH-1:0] lane;
  logic [DATA_WIDTH-1:0] load_ext;

  assign off        = i_alu_result[OFF_W-1:0];
  assign lane_shift = {off, 3'b000};
  assign access_ok  = i_mem_access & ~misaligned;
  assign is_load    = access_ok & ~i_mem_we;

  // Size-dependent alignment check and byte-enable base pattern
  always_comb begin
    misaligned = 1'b0;
    base_be    = 8'hFF;
    case (i_func3[1:0])
      2'd0: begin misaligned = 1'b0;       base_be = 8'h01; end
      2'd1: begin misaligned = off[0];     base_be = 8'h03; end
      2'd2: begin misaligned = |off[1:0];  base_be = 8'h0F; end
      default: begin misaligned = |off;    base_be = 8'hFF; end
    endcase
  end

  // Upstream is frozen by o_stall_mem, so the EX/MEM inputs hold address/data stable in REQ/WAIT_RD
  assign o_dmem_addr  = ADDR_WIDTH'({i_alu_result[DATA_WIDTH-1:OFF_W], OFF_W'(0)});
  assign o_dmem_be    = base_be << off;
  assign o_dmem_wdata = i_write_data << lane_shift;
  assign o_dmem_we    = o_dmem_req & i_mem_we;
  assign o_misaligned = (state == IDLE) & i_mem_access & misaligned;

  always_ff @(posedge i_clk) begin
    if (i_arst) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next  = state;
    o_dmem_req  = 1'b0;
    o_stall_mem = 1'b0;
    case (state)
      IDLE: begin
        o_dmem_req = access_ok;
        if (access_ok) begin
          if (!i_dmem_ready) begin
            o_stall_mem = 1'b1;
            state_next  = REQ;
          end else if (!i_mem_we) begin
            o_stall_mem = 1'b1;
            state_next  = WAIT_RD;
          end
        end
      end
      REQ: begin
        o_dmem_req  = 1'b1;
        o_stall_mem = ~(i_dmem_ready & i_mem_we);
        if (i_dmem_ready) state_next = i_mem_we ? IDLE : WAIT_RD;
      end
      WAIT_RD: begin
        o_stall_mem = ~i_dmem_rvalid;
        if (i_dmem_rvalid) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Load lane select and extension; func3 3 and 7 both return the full dword
  assign lane = i_dmem_rdata >> lane_shift;
  always_comb begin
    load_ext = lane;
    case (i_func3)
      3'd0: load_ext = {{(DATA_WIDTH-8){lane[7]}}, lane[7:0]};
      3'd1: load_ext = {{(DATA_WIDTH-16){lane[15]}}, lane[15:0]};
      3'd2: load_ext = {{(DATA_WIDTH-32){lane[31]}}, lane[31:0]};
      3'd4: load_ext = {{(DATA_WIDTH-8){1'b0}}, lane[7:0]};
      3'd5: load_ext = {{(DATA_WIDTH-16){1'b0}}, lane[15:0]};
      3'd6: load_ext = {{(DATA_WIDTH-32){1'b0}}, lane[31:0]};
      default: load_ext = lane;
    endcase
  end

  always_comb begin
    o_forward_value = i_alu_result;
    case (i_forward_src)
      2'd0: o_forward_value = i_alu_result;
      2'd1: o_forward_value = DATA_WIDTH'(i_pc_plus4);
      2'd2: o_forward_value = i_imm_ext;
      default: o_forward_value = DATA_WIDTH'(i_pc_target);
    endcase
  end

  // MEM/WB register: bubble (reg_we cleared, fields held) while stalled
  always_ff @(posedge i_clk) begin
    if (i_arst) begin
      o_result_src <= '0;
      o_reg_we     <= 1'b0;
      o_rd_addr    <= '0;
      o_pc_plus4   <= '0;
      o_pc_target  <= '0;
      o_imm_ext    <= '0;
      o_alu_result <= '0;
      o_read_data  <= '0;
    end else if (!o_stall_mem) begin
      o_result_src <= i_result_src;
      o_reg_we     <= i_reg_we & ~o_misaligned;
      o_rd_addr    <= i_rd_addr;
      o_pc_plus4   <= i_pc_plus4;
      o_pc_target  <= i_pc_target;
      o_imm_ext    <= i_imm_ext;
      o_alu_result <= i_alu_result;
      o_read_data  <= is_load ? load_ext : '0;
    end else begin
      o_reg_we     <= 1'b0;
    end
  end

endmodule

// File: tb/tb_memory_stage.sv
// Directed bench for memory_stage: reset, store lanes, load handshakes/extension,
// misalignment and forwarding, with hand-computed expectations.
module tb_memory_stage;

  logic        clk = 1'b0;
  logic        arst;
  logic [2:0]  result_src;
  logic        mem_we, reg_we, mem_access;
  logic [2:0]  func3;
  logic [63:0] pc_plus4, pc_target, imm_ext, alu_result, write_data;
  logic [1:0]  forward_src;
  logic [4:0]  rd_addr;
  logic        dmem_req, dmem_we;
  logic [63:0] dmem_addr, dmem_wdata;
  logic [7:0]  dmem_be;
  logic        dmem_ready, dmem_rvalid;
  logic [63:0] dmem_rdata;
  logic        stall_mem, misaligned;
  logic [63:0] forward_value;
  logic [2:0]  wb_result_src;
  logic        wb_reg_we;
  logic [4:0]  wb_rd_addr;
  logic [63:0] wb_pc_plus4, wb_pc_target, wb_imm_ext, wb_alu_result, wb_read_data;

  int checks = 0;
  int errors = 0;
  int stalls;

  always #5 clk = ~clk;

  memory_stage dut (
    .i_clk(clk), .i_arst(arst), .i_result_src(result_src), .i_mem_we(mem_we),
    .i_reg_we(reg_we), .i_mem_access(mem_access), .i_func3(func3),
    .i_pc_plus4(pc_plus4), .i_pc_target(pc_target), .i_imm_ext(imm_ext),
    .i_alu_result(alu_result), .i_write_data(write_data), .i_forward_src(forward_src),
    .i_rd_addr(rd_addr), .o_dmem_req(dmem_req), .o_dmem_we(dmem_we),
    .o_dmem_addr(dmem_addr), .o_dmem_wdata(dmem_wdata), .o_dmem_be(dmem_be),
    .i_dmem_ready(dmem_ready), .i_dmem_rvalid(dmem_rvalid), .i_dmem_rdata(dmem_rdata),
    .o_stall_mem(stall_mem), .o_misaligned(misaligned), .o_forward_value(forward_value),
    .o_result_src(wb_result_src), .o_reg_we(wb_reg_we), .o_rd_addr(wb_rd_addr),
    .o_pc_plus4(wb_pc_plus4), .o_pc_target(wb_pc_target), .o_imm_ext(wb_imm_ext),
    .o_alu_result(wb_alu_result), .o_read_data(wb_read_data)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic clear_inputs();
    result_src = 3'd0; mem_we = 1'b0; reg_we = 1'b0; mem_access = 1'b0; func3 = 3'd0;
    pc_plus4 = '0; pc_target = '0; imm_ext = '0; alu_result = '0; write_data = '0;
    forward_src = 2'd0; rd_addr = 5'd0;
    dmem_ready = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = '0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Load with rdy_wait not-ready cycles, then rv_wait cycles before rvalid; counts stall cycles
  task automatic run_load(input string tag, input logic [2:0] f3, input logic [63:0] addr,
                          input logic [63:0] rdata, input int rdy_wait, input int rv_wait,
                          input logic [4:0] rd, input logic [63:0] exp_data, output int n_stall);
    int k;
    k = 0;
    n_stall = 0;
    mem_access = 1'b1; mem_we = 1'b0; reg_we = 1'b1; func3 = f3;
    alu_result = addr; rd_addr = rd; dmem_rdata = 64'h0BAD_0BAD_0BAD_0BAD;
    for (int c = 0; c <= rdy_wait; c++) begin
      dmem_ready = (c == rdy_wait);
      #1;
      check({tag, "_req"}, 64'(dmem_req), 64'd1);
      check({tag, "_addr"}, dmem_addr, {addr[63:3], 3'b000});
      if (k > 0) check({tag, "_bubble"}, 64'(wb_reg_we), 64'd0);
      if (stall_mem) n_stall++;
      k++;
      next_cycle();
    end
    dmem_ready = 1'b0;
    for (int c = 0; c < rv_wait; c++) begin
      #1;
      check({tag, "_wait_req"}, 64'(dmem_req), 64'd0);
      check({tag, "_bubble"}, 64'(wb_reg_we), 64'd0);
      if (stall_mem) n_stall++;
      next_cycle();
    end
    dmem_rvalid = 1'b1; dmem_rdata = rdata;
    #1;
    check({tag, "_rvalid_stall"}, 64'(stall_mem), 64'd0);
    next_cycle();
    dmem_rvalid = 1'b0;
    check({tag, "_data"}, wb_read_data, exp_data);
    check({tag, "_wb_we"}, 64'(wb_reg_we), 64'd1);
    check({tag, "_wb_rd"}, 64'(wb_rd_addr), 64'(rd));
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    arst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_stall", 64'(stall_mem), 64'd0);
    check("rst_req", 64'(dmem_req), 64'd0);
    check("rst_wb_we", 64'(wb_reg_we), 64'd0);
    check("rst_wb_data", wb_read_data, 64'd0);
    arst = 1'b0;

    // Reset arriving while a load waits for data
    mem_access = 1'b1; func3 = 3'd3; alu_result = 64'h4000; reg_we = 1'b1; rd_addr = 5'd4;
    dmem_ready = 1'b1;
    next_cycle();
    dmem_ready = 1'b0;
    arst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    arst = 1'b0;
    clear_inputs();
    dmem_rvalid = 1'b1; dmem_rdata = 64'hDEAD_BEEF_DEAD_BEEF;
    #1;
    check("rst1_stall", 64'(stall_mem), 64'd0);
    check("rst1_req", 64'(dmem_req), 64'd0);
    next_cycle();
    check("rst1_wb_data", wb_read_data, 64'd0);
    check("rst1_wb_we", 64'(wb_reg_we), 64'd0);
    // rvalid must be ignored in IDLE: a new load issues and stalls
    mem_access = 1'b1; func3 = 3'd4; alu_result = 64'h6001; reg_we = 1'b1; rd_addr = 5'd6;
    dmem_ready = 1'b1;
    #1;
    check("rst1_new_req", 64'(dmem_req), 64'd1);
    check("rst1_new_stall", 64'(stall_mem), 64'd1);
    next_cycle();
    dmem_ready = 1'b0; dmem_rdata = 64'h0000_0000_0000_5A00;
    #1;
    check("rst1_new_done", 64'(stall_mem), 64'd0);
    next_cycle();
    check("rst1_new_data", wb_read_data, 64'h5A);
    clear_inputs();

    // sb with immediate ready
    mem_access = 1'b1; mem_we = 1'b1; func3 = 3'd0; alu_result = 64'h1005;
    write_data = 64'hAB; dmem_ready = 1'b1;
    #1;
    check("sb_req", 64'(dmem_req), 64'd1);
    check("sb_we", 64'(dmem_we), 64'd1);
    check("sb_addr", dmem_addr, 64'h1000);
    check("sb_be", 64'(dmem_be), 64'h20);
    check("sb_wdata", dmem_wdata, 64'h0000_AB00_0000_0000);
    check("sb_stall", 64'(stall_mem), 64'd0);
    next_cycle();
    check("sb_wb_alu", wb_alu_result, 64'h1005);
    check("sb_wb_data", wb_read_data, 64'd0);
    clear_inputs();
    check("sb_after_stall", 64'(stall_mem), 64'd0);

    // sh lanes
    mem_access = 1'b1; mem_we = 1'b1; func3 = 3'd1; alu_result = 64'h1002;
    write_data = 64'h1234; dmem_ready = 1'b1;
    #1;
    check("sh_be", 64'(dmem_be), 64'h0C);
    check("sh_wdata", dmem_wdata, 64'h0000_0000_1234_0000);
    next_cycle();
    clear_inputs();

    // lb with ready after 2 cycles and one data-wait cycle
    run_load("lb", 3'd0, 64'h2003, 64'h7766_5544_8033_2211, 2, 1, 5'd7,
             64'hFFFF_FFFF_FFFF_FF80, stalls);
    check("lb_stalls", 64'(stalls), 64'd4);
    run_load("lbu", 3'd4, 64'h2003, 64'h7766_5544_8033_2211, 0, 0, 5'd8,
             64'h80, stalls);
    check("lbu_stalls", 64'(stalls), 64'd1);
    run_load("ld", 3'd3, 64'h4000, 64'h0123_4567_89AB_CDEF, 0, 3, 5'd9,
             64'h0123_4567_89AB_CDEF, stalls);
    check("ld_stalls", 64'(stalls), 64'd4);
    run_load("lh", 3'd1, 64'h5002, 64'h0000_0000_9ABC_0000, 0, 0, 5'd10,
             64'hFFFF_FFFF_FFFF_9ABC, stalls);
    run_load("lwu", 3'd6, 64'h5004, 64'hF123_4567_0000_0000, 1, 0, 5'd11,
             64'h0000_0000_F123_4567, stalls);
    run_load("lw", 3'd2, 64'h5004, 64'hF123_4567_0000_0000, 0, 0, 5'd12,
             64'hFFFF_FFFF_F123_4567, stalls);
    run_load("f3_7", 3'd7, 64'h5000, 64'h8000_0000_0000_0001, 0, 0, 5'd13,
             64'h8000_0000_0000_0001, stalls);

    // Misaligned lw
    mem_access = 1'b1; func3 = 3'd2; alu_result = 64'h3006; reg_we = 1'b1; rd_addr = 5'd14;
    dmem_ready = 1'b1;
    #1;
    check("mis_flag", 64'(misaligned), 64'd1);
    check("mis_req", 64'(dmem_req), 64'd0);
    check("mis_stall", 64'(stall_mem), 64'd0);
    next_cycle();
    clear_inputs();
    #1;
    check("mis_flag_clear", 64'(misaligned), 64'd0);
    check("mis_wb_we", 64'(wb_reg_we), 64'd0);
    check("mis_wb_alu", wb_alu_result, 64'h3006);
    check("mis_wb_rd", 64'(wb_rd_addr), 64'd14);

    // Non-memory op and forwarding select
    @(negedge clk);
    reg_we = 1'b1; rd_addr = 5'd3; alu_result = 64'h55; pc_plus4 = 64'h104;
    imm_ext = 64'h7FF; pc_target = 64'h2000; forward_src = 2'd1; result_src = 3'd2;
    #1;
    check("fwd_pc4", forward_value, 64'h104);
    check("nm_stall", 64'(stall_mem), 64'd0);
    check("nm_req", 64'(dmem_req), 64'd0);
    forward_src = 2'd0; #1; check("fwd_alu", forward_value, 64'h55);
    forward_src = 2'd2; #1; check("fwd_imm", forward_value, 64'h7FF);
    forward_src = 2'd3; #1; check("fwd_tgt", forward_value, 64'h2000);
    next_cycle();
    check("nm_wb_pc4", wb_pc_plus4, 64'h104);
    check("nm_wb_we", 64'(wb_reg_we), 64'd1);
    check("nm_wb_rd", 64'(wb_rd_addr), 64'd3);
    check("nm_wb_src", 64'(wb_result_src), 64'd2);
    check("nm_wb_tgt", wb_pc_target, 64'h2000);
    check("nm_wb_data", wb_read_data, 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/memory_stage.md
Name: memory_stage

Overview:
Pipeline MEM stage, directly downstream of the execute stage; consumes the EX/MEM pipeline-register outputs.
- Issues aligned 64-bit data-memory requests with byte enables over a ready/valid handshake.
- Sign/zero-extends load data and asserts o_stall_mem back to the execute stage while an access is outstanding.
- Provides the MEM-stage forwarding value and contains the MEM/WB pipeline register.

Parameters:
ADDR_WIDTH, 64, address width
DATA_WIDTH, 64, data width (memory word = 8 bytes)
REG_ADDR_W, 5, register index width

Ports:
i_clk  in  1  clock, all state on rising edge
i_arst  in  1  reset, synchronous, active-high
i_result_src  in  3  writeback result select, passed to WB
i_mem_we  in  1  store when 1, load when 0 (valid with i_mem_access)
i_reg_we  in  1  register write enable
i_mem_access  in  1  instruction is a load/store
i_func3  in  3  access size/sign
i_pc_plus4 / i_pc_target  in  ADDR_WIDTH  passthrough values
i_imm_ext / i_alu_result / i_write_data  in  DATA_WIDTH  imm, address/result, store data
i_forward_src  in  2  forwarding select
i_rd_addr  in  REG_ADDR_W  destination register
o_dmem_req  out  1  request valid
o_dmem_we  out  1  request is store
o_dmem_addr  out  ADDR_WIDTH  {i_alu_result[63:3], 3'b0}
o_dmem_wdata  out  DATA_WIDTH  lane-shifted store data
o_dmem_be  out  8  byte enables
i_dmem_ready  in  1  request accepted this cycle
i_dmem_rvalid  in  1  load data valid
i_dmem_rdata  in  DATA_WIDTH  load word
o_stall_mem  out  1  freeze upstream stages
o_misaligned  out  1  one-cycle misaligned-access flag
o_forward_value  out  DATA_WIDTH  value forwarded to execute
o_result_src, o_reg_we, o_rd_addr, o_pc_plus4, o_pc_target, o_imm_ext, o_alu_result, o_read_data  out  as inputs  MEM/WB register outputs (o_read_data DATA_WIDTH)

Behaviour:
Reset
- When i_arst is high at a rising edge: FSM -> IDLE and every MEM/WB register clears to 0.
- While the FSM is in IDLE and no aligned access is present, o_dmem_req = 0 and o_stall_mem = 0.

Alignment
- off = i_alu_result[2:0].
- Misaligned when: func3[1:0] = 1 and off[0] != 0; func3[1:0] = 2 and off[1:0] != 0; func3[1:0] = 3 and off != 0.
- On a misaligned access: no request, o_misaligned = 1 combinationally, no stall, and the MEM/WB register captures with reg_we forced to 0.

Store lanes
- o_dmem_be = {0x01, 0x03, 0x0F, 0xFF}[func3[1:0]] << off.
- o_dmem_wdata = i_write_data << (8*off).

FSM
- IDLE:
  - o_dmem_req = i_mem_access & ~misaligned.
  - If req & ready: a store completes with no stall; a load goes to WAIT_RD with stall = 1.
  - If req & ~ready: go to REQ, stall = 1.
- REQ:
  - req = 1; address, be and wdata stay stable.
  - stall = ~(ready & store).
  - On ready: a store returns to IDLE; a load goes to WAIT_RD.
- WAIT_RD:
  - req = 0; stall = ~i_dmem_rvalid.
  - On rvalid: capture the extended data and return to IDLE.
- i_dmem_rvalid is ignored in IDLE/REQ, including a response outstanding across reset.

Load extension
- Select the byte/half/word/dword at off from i_dmem_rdata.
- func3 0 = lb, 1 = lh, 2 = lw, 3 = ld: sign-extend.
- func3 4 = lbu, 5 = lhu, 6 = lwu: zero-extend.
- func3 7 on a load: treated as ld.

MEM/WB register
- When o_stall_mem = 0: captures all fields; o_read_data gets the extended data, or 0 for non-loads.
- When o_stall_mem = 1: loads a bubble (o_reg_we = 0, other fields hold).

Forwarding
- o_forward_value is combinational on i_forward_src: 0 = i_alu_result, 1 = i_pc_plus4, 2 = i_imm_ext, 3 = i_pc_target.

Latency
- Non-memory op: 1 cycle.
- Store: 1 cycle when ready is immediate.
- Load: ≥ 2 cycles.

Test Plan:
1. Reset high 2 cycles mid-WAIT_RD, then rvalid=1 after release -> all outputs 0, FSM IDLE, no write-back of the stale data.
2. sb: alu_result=0x1005, write_data=0xAB, ready=1 immediately -> addr=0x1000, be=0x20, wdata[47:40]=0xAB, o_stall_mem=0 throughout.
3. lb: addr=0x2003, ready after 2 cycles, rdata byte3=0x80 -> stall asserted 2 cycles in REQ then until rvalid; o_read_data=0xFFFF_FFFF_FFFF_FF80; lbu gives 0x80.
4. lw: addr=0x3006 -> o_misaligned=1 for 1 cycle, o_dmem_req=0, o_stall_mem=0, o_reg_we=0 in WB.
5. ld: addr=0x4000, ready=1, rvalid 3 cycles later -> o_stall_mem high 4 cycles; WB sees bubbles (reg_we=0) during the stall, then the full 64-bit rdata with reg_we=1.
6. Non-memory op: forward_src=1, pc_plus4=0x104 -> o_forward_value=0x104 same cycle; MEM/WB updates next edge with no stall.
